// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift-register path: FSM states and
// the direction encoding used by both the shift-register control and the deserializer.
package shift_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial-in / parallel-out handshake bundle between a bit source/word consumer
// (master) and the deserializer (slave).
interface shift_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Start;
    logic             Dir;
    logic             Bit_In;
    logic             Bit_Valid;
    logic             Data_Ack;
    logic [WIDTH-1:0] Data_Out;
    logic             Data_Valid;
    logic             Busy;
    logic             Overrun;

    modport master (
        output Start, Dir, Bit_In, Bit_Valid, Data_Ack,
        input  Data_Out, Data_Valid, Busy, Overrun
    );

    modport slave (
        input  Start, Dir, Bit_In, Bit_Valid, Data_Ack,
        output Data_Out, Data_Valid, Busy, Overrun
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel capture: assembles WIDTH bits shifted in either direction
// into a word, presented with a level valid/ack handshake and sticky overrun.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input logic                 Clk,
    input logic                 Reset,
    shift_deserializer_if.slave bus
);

    localparam logic [0:0] S_IDLE  = 1'(IDLE);
    localparam logic [0:0] S_SHIFT = 1'(SHIFT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] sreg_q, sreg_n;
    logic             dir_q, dir_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             valid_q, valid_n;
    logic             busy_q, busy_n;
    logic             overrun_q, overrun_n;
    logic [WIDTH-1:0] word_c;

    // Register file for FSM, datapath and all outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            dir_q     <= DIR_MSB_FIRST;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sreg_q    <= sreg_n;
            dir_q     <= dir_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            busy_q    <= busy_n;
            overrun_q <= overrun_n;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        sreg_n    = sreg_q;
        dir_n     = dir_q;
        data_n    = data_q;
        valid_n   = valid_q;
        overrun_n = overrun_q;

        word_c = (dir_q == DIR_LSB_FIRST) ? {bus.Bit_In, sreg_q[WIDTH-1:1]}
                                          : {sreg_q[WIDTH-2:0], bus.Bit_In};

        if (valid_q && bus.Data_Ack) begin
            valid_n = 1'b0;
        end

        // Start restarts from either state and beats a same-cycle completion.
        if (bus.Start) begin
            dir_n     = bus.Dir;
            sreg_n    = '0;
            cnt_n     = '0;
            overrun_n = 1'b0;
            state_n   = S_SHIFT;
        end else if (state_q == S_SHIFT && bus.Bit_Valid) begin
            if (cnt_q == CNT_LAST) begin
                data_n  = word_c;
                valid_n = 1'b1;
                if (valid_q && !bus.Data_Ack) begin
                    overrun_n = 1'b1;
                end
                sreg_n  = word_c;
                cnt_n   = '0;
                state_n = S_IDLE;
            end else begin
                sreg_n = word_c;
                cnt_n  = cnt_q + CNT_W'(1);
            end
        end

        busy_n = (state_n == S_SHIFT);
    end

    assign bus.Data_Out   = data_q;
    assign bus.Data_Valid = valid_q;
    assign bus.Busy       = busy_q;
    assign bus.Overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus random
// traffic against a queue-based word-assembly reference model.
module tb_shift_deserializer;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_deserializer_if #(.WIDTH(W)) bus ();

    shift_deserializer #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits collected in a queue, word built by position arithmetic.
    bit       m_busy;
    bit       m_dir;
    bit       m_valid;
    bit       m_overrun;
    bit [W-1:0] m_data;
    bit       m_bits[$];

    function automatic bit [W-1:0] assemble(input bit dir, input bit q[$]);
        bit [W-1:0] w;
        w = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (dir) w[i] = q[i];
            else     w[W-1-i] = q[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dir = 0; m_valid = 0; m_overrun = 0; m_data = '0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit s, input bit d, input bit b, input bit bv, input bit a);
        bit was_valid;
        was_valid = m_valid;
        if (was_valid && a) m_valid = 0;
        if (s) begin
            m_busy = 1; m_dir = d; m_overrun = 0;
            m_bits.delete();
        end else if (m_busy && bv) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                m_data  = assemble(m_dir, m_bits);
                m_valid = 1;
                if (was_valid && !a) m_overrun = 1;
                m_busy = 0;
                m_bits.delete();
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, return 1 time unit after it.
    task automatic cyc(input bit s, input bit d, input bit b, input bit bv, input bit a);
        bus.Start = s; bus.Dir = d; bus.Bit_In = b; bus.Bit_Valid = bv; bus.Data_Ack = a;
        @(posedge clk);
        model_step(s, d, b, bv, a);
        #1;
        bus.Start = 0; bus.Bit_Valid = 0; bus.Data_Ack = 0;
    endtask

    task automatic send_word(input bit d, input bit [W-1:0] w, input bit ack_last);
        bit [W-1:0] v;
        v = w;
        cyc(1, d, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            cyc(0, ~d, d ? v[i] : v[W-1-i], 1, ack_last && (i == W - 1));
        end
    endtask

    task automatic test_reset();
        if (bus.Data_Out !== '0 || bus.Data_Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Overrun !== 1'b0) begin
            $display("FAIL reset_values: out=%h valid=%b busy=%b ovr=%b expected all 0",
                     bus.Data_Out, bus.Data_Valid, bus.Busy, bus.Overrun);
            errors++;
        end
        checks++;
    endtask

    task automatic test_msb_first();
        bit [W-1:0] v;
        v = 8'h32;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            cyc(0, 0, v[W-1-i], 1, 0);
            if (i == W - 2) begin
                if (bus.Busy !== 1'b1 || bus.Data_Valid !== 1'b0) begin
                    $display("FAIL msb_before_last: busy=%b valid=%b expected busy=1 valid=0", bus.Busy, bus.Data_Valid);
                    errors++;
                end
                checks++;
            end
        end
        if (bus.Data_Out !== 8'h32 || bus.Data_Valid !== 1'b1 || bus.Busy !== 1'b0) begin
            $display("FAIL msb_word: out=%h valid=%b busy=%b expected 32/1/0", bus.Data_Out, bus.Data_Valid, bus.Busy);
            errors++;
        end
        checks++;
        cyc(0, 0, 0, 0, 1);
        if (bus.Data_Valid !== 1'b0) begin
            $display("FAIL ack_clears: valid=%b expected 0", bus.Data_Valid);
            errors++;
        end
        checks++;
    endtask

    task automatic test_lsb_gaps();
        bit [W-1:0] v;
        bit early;
        v = 8'h32;
        early = 0;
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            cyc(0, 0, v[i], 1, 0);
            if (i < W - 1) begin
                if (bus.Data_Valid) early = 1;
                cyc(0, 0, 1, 0, 0);
                if (bus.Data_Valid) early = 1;
            end
        end
        if (early !== 1'b0) begin
            $display("FAIL lsb_no_early_valid: early=%b expected 0", early);
            errors++;
        end
        checks++;
        if (bus.Data_Out !== 8'h32 || bus.Data_Valid !== 1'b1) begin
            $display("FAIL lsb_word: out=%h valid=%b expected 32/1", bus.Data_Out, bus.Data_Valid);
            errors++;
        end
        checks++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_overrun();
        send_word(0, 8'hA5, 0);
        send_word(0, 8'h3C, 0);
        if (bus.Data_Out !== 8'h3C || bus.Data_Valid !== 1'b1 || bus.Overrun !== 1'b1) begin
            $display("FAIL overrun_set: out=%h valid=%b ovr=%b expected 3c/1/1", bus.Data_Out, bus.Data_Valid, bus.Overrun);
            errors++;
        end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (bus.Overrun !== 1'b0 || bus.Data_Valid !== 1'b1) begin
            $display("FAIL overrun_cleared_by_start: ovr=%b valid=%b expected 0/1", bus.Overrun, bus.Data_Valid);
            errors++;
        end
        checks++;
        cyc(0, 0, 0, 0, 1);
        send_word(0, 8'hA5, 0);
        send_word(0, 8'h3C, 1);
        if (bus.Data_Out !== 8'h3C || bus.Data_Valid !== 1'b1 || bus.Overrun !== 1'b0) begin
            $display("FAIL ack_on_completion: out=%h valid=%b ovr=%b expected 3c/1/0", bus.Data_Out, bus.Data_Valid, bus.Overrun);
            errors++;
        end
        checks++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_restart();
        bit [W-1:0] v;
        int rises;
        v = 8'hF0;
        rises = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);
        if (bus.Data_Valid !== 1'b0 || bus.Busy !== 1'b1) begin
            $display("FAIL restart_state: valid=%b busy=%b expected 0/1", bus.Data_Valid, bus.Busy);
            errors++;
        end
        checks++;
        for (int i = 0; i < W; i++) begin
            cyc(0, 0, v[i], 1, 0);
            if (bus.Data_Valid) rises++;
        end
        if (bus.Data_Out !== 8'hF0 || rises != 1) begin
            $display("FAIL restart_word: out=%h valid_cycles=%0d expected f0/1", bus.Data_Out, rises);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_midword();
        bit [W-1:0] v;
        v = 8'h5A;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, v[W-1-i], 1, 0);
        rst_n = 0;
        #1;
        model_reset();
        if (bus.Data_Out !== '0 || bus.Data_Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Overrun !== 1'b0) begin
            $display("FAIL async_reset: out=%h valid=%b busy=%b ovr=%b expected all 0",
                     bus.Data_Out, bus.Data_Valid, bus.Busy, bus.Overrun);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0);
            if (bus.Data_Valid !== 1'b0 || bus.Busy !== 1'b0) begin
                $display("FAIL no_capture_after_reset: valid=%b busy=%b expected 0/0", bus.Data_Valid, bus.Busy);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_ignored_bits();
        bit [W-1:0] v;
        v = 8'h81;
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        if (bus.Busy !== 1'b0 || bus.Data_Valid !== 1'b0) begin
            $display("FAIL idle_ignores_bits: busy=%b valid=%b expected 0/0", bus.Busy, bus.Data_Valid);
            errors++;
        end
        checks++;
        cyc(1, 0, 1, 1, 0);
        for (int i = 0; i < W; i++) cyc(0, 0, v[W-1-i], 1, 0);
        if (bus.Data_Out !== 8'h81 || bus.Data_Valid !== 1'b1) begin
            $display("FAIL ignored_bit_word: out=%h valid=%b expected 81/1", bus.Data_Out, bus.Data_Valid);
            errors++;
        end
        checks++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_start_at_completion();
        bit [W-1:0] v;
        v = 8'hC3;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < W - 1; i++) cyc(0, 0, v[W-1-i], 1, 0);
        cyc(1, 0, v[0], 1, 0);
        if (bus.Data_Valid !== 1'b0 || bus.Busy !== 1'b1 || bus.Data_Out !== m_data) begin
            $display("FAIL start_beats_completion: valid=%b busy=%b out=%h expected 0/1/%h",
                     bus.Data_Valid, bus.Busy, bus.Data_Out, m_data);
            errors++;
        end
        checks++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
            if (bus.Data_Out !== m_data || bus.Data_Valid !== m_valid ||
                bus.Busy !== m_busy || bus.Overrun !== m_overrun) begin
                $display("FAIL random_cycle_%0d: out=%h valid=%b busy=%b ovr=%b expected %h/%b/%b/%b",
                         n, bus.Data_Out, bus.Data_Valid, bus.Busy, bus.Overrun,
                         m_data, m_valid, m_busy, m_overrun);
                errors++;
            end
            checks++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 0;
        bus.Start = 0; bus.Dir = 0; bus.Bit_In = 0; bus.Bit_Valid = 0; bus.Data_Ack = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1;
        test_msb_first();
        test_lsb_gaps();
        test_overrun();
        test_restart();
        test_reset_midword();
        test_ignored_bits();
        test_start_at_completion();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel capture block forming the receive end of the universal shift-register path: it collects bits shifted out one per enabled cycle, in either direction, and reassembles a WIDTH-bit word. A completed word is presented with a level valid/acknowledge handshake, and overrun is flagged. It sits downstream of the shift-register output pin, feeding parallel consumers.

## Interface
- WIDTH, 8: word length in bits, minimum 2.
- CNT_W, $clog2(WIDTH): bit-counter width.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- Start  input  1  begin/restart capture of one word; latches Dir.
- Dir  input  1  0 = MSB first (shift left, new bit into bit 0); 1 = LSB first (shift right, new bit into bit WIDTH-1).
- Bit_In  input  1  serial data bit.
- Bit_Valid  input  1  Bit_In is sampled this edge.
- Data_Ack  input  1  consumer accepts Data_Out.
- Data_Out  output  WIDTH  last completed word.
- Data_Valid  output  1  Data_Out holds an unacknowledged word.
- Busy  output  1  capture in progress (state SHIFT).
- Overrun  output  1  sticky; a word completed while the previous one was unacknowledged.

## Operation
- States: IDLE, SHIFT.
- IDLE: Start=1 → latch Dir, clear shift register and counter to 0, clear Overrun, go to SHIFT. Bit_Valid is ignored in IDLE.
- SHIFT, Bit_Valid=1, Start=0: shift Bit_In in per latched Dir, counter+1.
- When counter = WIDTH-1 and Bit_Valid=1, the word is complete:
  - Data_Out ← assembled word, including this bit.
  - Data_Valid ← 1.
  - Counter ← 0; state → IDLE.
- SHIFT, Start=1: abort the partial word and restart with counter 0 and Dir relatched. A Bit_Valid in the same cycle is discarded. Data_Out and Data_Valid are unaffected.
- Handshake: Data_Valid=1 and Data_Ack=1 at an edge clears Data_Valid. Data_Ack while Data_Valid=0 has no effect.
- Completion while Data_Valid=1:
  - With Data_Ack=1 the same edge: Data_Out takes the new word, Data_Valid stays 1, no overrun.
  - With Data_Ack=0: Data_Out is overwritten, Data_Valid stays 1, Overrun ← 1. Overrun stays set until Start or Reset.
- Dir changes while in SHIFT are ignored.

## Timing
- Reset values: Data_Out=0, Data_Valid=0, Busy=0, Overrun=0, state IDLE, counter 0, shift register 0.
- Reset mid-word: the partial word is lost with no Data_Valid. Capture resumes only on a new Start after Reset returns to 1.
- Busy is high from the edge after Start until the edge that samples the WIDTH-th bit, registered.
- Latency: Data_Valid and Data_Out update at the edge sampling the WIDTH-th valid bit and are visible the same cycle after that edge. Minimum word time is 1 Start cycle plus WIDTH Bit_Valid cycles.
- Gaps (Bit_Valid=0) inside SHIFT are unlimited; state and counter hold.
- Start in the cycle of completion: restart wins and the word is discarded. Data_Valid is not set.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Shared package shift_pkg:
  - state enum {IDLE, SHIFT}.
  - Direction constants DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1, shared with the shift-register control encoding.
- Single module; no sub-module is warranted. Counter, shift register and FSM are inline.

## Test plan
- MSB first, 0x32: Start with Dir=0, then bits 0,0,1,1,0,0,1,0 on consecutive Bit_Valid → Data_Out=8'h32, Data_Valid=1 after the 8th edge, Busy falls the same edge.
- LSB first, 0x32 with gaps: Dir=1, bits 0,1,0,0,1,1,0,0 with Bit_Valid low every other cycle → Data_Out=8'h32. No early Data_Valid.
- Handshake and overrun:
  - Word 8'hA5 left unacked, then second word 8'h3C → Data_Out=8'h3C, Overrun=1.
  - Next Start clears Overrun.
  - Data_Ack on the completion edge of the second word → Overrun stays 0.
- Restart mid-word: 4 bits, then Start with Dir=1, then 8 bits of 8'hF0 LSB first → Data_Out=8'hF0 with exactly one Data_Valid.
- Reset mid-word: Reset low after 5 bits → all outputs 0 immediately (asynchronous). After release, 3 more bits without Start → no Data_Valid.
- Bit_Valid in IDLE and Start+Bit_Valid in the same cycle: the ignored bit must not appear in the word 8'h81.
